// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: state encoding, March element ids and per-element selects
// shared by the RAM BIST controller and its address generator.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0_W,
    S_M1_R,
    S_M1_WT,
    S_M1_W,
    S_M2_R,
    S_M2_WT,
    S_M2_W,
    S_M3_R,
    S_M3_WT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    EL_M0,
    EL_M1,
    EL_M2,
    EL_M3
  } elem_t;

  // Map an FSM state onto the March element it belongs to.
  function automatic elem_t state_elem(input state_t s);
    case (s)
      S_M1_R, S_M1_WT, S_M1_W: return EL_M1;
      S_M2_R, S_M2_WT, S_M2_W: return EL_M2;
      S_M3_R, S_M3_WT:         return EL_M3;
      default:                 return EL_M0;
    endcase
  endfunction

  // M2 and M3 walk the address space downwards.
  function automatic logic elem_down(input elem_t e);
    return (e == EL_M2) || (e == EL_M3);
  endfunction

  // Only M2 expects to read back the inverted background.
  function automatic logic elem_exp_inv(input elem_t e);
    return (e == EL_M2);
  endfunction

  // Only M1 writes the inverted background.
  function automatic logic elem_wr_inv(input elem_t e);
    return (e == EL_M1);
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: up/down address counter with load-0 / load-max and a
// terminal-count flag for the current direction.
module ram_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_zero,
  input  logic              load_max,
  input  logic              step,
  input  logic              dir_down,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next address: loads take priority over stepping.
  always_comb begin
    addr_d = addr_q;
    if (load_zero)      addr_d = '0;
    else if (load_max)  addr_d = '1;
    else if (step)      addr_d = dir_down ? (addr_q - ONE) : (addr_q + ONE);
  end

  // Address register; reset to 0 so the RAM address port reads 0 after rst.
  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign tc   = dir_down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March C- style self-test controller driving a single-port RAM.
// M0 up w(P); M1 up r(P),w(~P); M2 down r(~P),w(P); M3 down r(P).
// Build macro BIST_ERR_COUNT_EN: keep running after mismatches and report a
// saturating mismatch count on err_cnt; otherwise stop at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] PATTERN  = 8'h55
`ifdef BIST_ERR_COUNT_EN
  ,
  parameter int                ERR_W    = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef BIST_ERR_COUNT_EN
  ,
  output logic [ERR_W-1:0]  err_cnt
`endif
);

  localparam logic [2:0] WT_LAST = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        wt_q, wt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_seen_q, fail_seen_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
`ifdef BIST_ERR_COUNT_EN
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
`endif

  logic              ag_load_zero, ag_load_max, ag_step, ag_tc;
  logic [ADDR_W-1:0] ag_addr;
  elem_t             cur_el;
  logic [DATA_W-1:0] exp_val;
  logic              rd_last, mismatch;

  assign cur_el   = state_elem(state_q);
  assign exp_val  = elem_exp_inv(cur_el) ? ~PATTERN : PATTERN;
  // ram_dout is only meaningful in the last wait cycle of a read.
  assign rd_last  = (state_q inside {S_M1_WT, S_M2_WT, S_M3_WT}) && (wt_q == WT_LAST);
  assign mismatch = rd_last && (ram_dout != exp_val);

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_zero (ag_load_zero),
    .load_max  (ag_load_max),
    .step      (ag_step),
    .dir_down  (elem_down(cur_el)),
    .addr      (ag_addr),
    .tc        (ag_tc)
  );

  // Next state, address-generator control, result capture and the registered
  // RAM/status outputs, all derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    wt_d         = wt_q;
    pass_d       = pass_q;
    fail_seen_d  = fail_seen_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    ag_load_zero = 1'b0;
    ag_load_max  = 1'b0;
    ag_step      = 1'b0;
`ifdef BIST_ERR_COUNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_M0_W;
          ag_load_zero = 1'b1;
          pass_d       = 1'b0;
          fail_seen_d  = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
`ifdef BIST_ERR_COUNT_EN
          err_cnt_d    = '0;
`endif
        end
      end
      S_M0_W: begin
        if (ag_tc) begin
          state_d      = S_M1_R;
          ag_load_zero = 1'b1;
        end else begin
          ag_step = 1'b1;
        end
      end
      S_M1_R: begin
        state_d = S_M1_WT;
        wt_d    = '0;
      end
      S_M1_WT: begin
        if (rd_last) state_d = S_M1_W;
        else         wt_d    = wt_q + 3'd1;
      end
      S_M1_W: begin
        if (ag_tc) begin
          state_d     = S_M2_R;
          ag_load_max = 1'b1;
        end else begin
          state_d = S_M1_R;
          ag_step = 1'b1;
        end
      end
      S_M2_R: begin
        state_d = S_M2_WT;
        wt_d    = '0;
      end
      S_M2_WT: begin
        if (rd_last) state_d = S_M2_W;
        else         wt_d    = wt_q + 3'd1;
      end
      S_M2_W: begin
        if (ag_tc) begin
          state_d     = S_M3_R;
          ag_load_max = 1'b1;
        end else begin
          state_d = S_M2_R;
          ag_step = 1'b1;
        end
      end
      S_M3_R: begin
        state_d = S_M3_WT;
        wt_d    = '0;
      end
      S_M3_WT: begin
        if (rd_last) begin
          if (ag_tc) begin
            state_d = S_DONE;
          end else begin
            state_d = S_M3_R;
            ag_step = 1'b1;
          end
        end else begin
          wt_d = wt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the first mismatch is recorded in fail_addr/fail_data.
    if (mismatch) begin
      if (!fail_seen_q) begin
        fail_addr_d = ag_addr;
        fail_data_d = ram_dout;
      end
      fail_seen_d = 1'b1;
`ifdef BIST_ERR_COUNT_EN
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_ONE;
`else
      state_d     = S_DONE;
      ag_step     = 1'b0;
      ag_load_max = 1'b0;
`endif
    end

    if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = !fail_seen_d;

    busy_d    = !(state_d inside {S_IDLE, S_DONE});
    done_d    = (state_d == S_DONE);
    ram_we_d  = (state_d inside {S_M0_W, S_M1_W, S_M2_W});
    ram_din_d = '0;
    if (ram_we_d) ram_din_d = elem_wr_inv(state_elem(state_d)) ? ~PATTERN : PATTERN;
  end

  // Single state/output register; reset forces IDLE and every output low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wt_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
`ifdef BIST_ERR_COUNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wt_q        <= wt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
`ifdef BIST_ERR_COUNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ag_addr;
  assign ram_din   = ram_din_q;
`ifdef BIST_ERR_COUNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule
